// File: rtl/sdio_cia_xfer_ctrl_if.sv
// Bundle of request, upstream byte stream and CIA target handshake signals
// for sdio_cia_xfer_ctrl. Signal names keep the bridge's point of view:
// i_* are driven into the bridge, o_* are driven by it.
//   slave  : the transfer controller itself
//   master : whatever sits around it (command layer plus register target)
interface sdio_cia_xfer_ctrl_if;

    // request from the command layer
    logic        i_cmd_stb;
    logic        i_write_flag;
    logic        i_inc_addr;
    logic [17:0] i_address;
    logic [17:0] i_data_count;
    logic        i_abort;

    // upstream write byte stream
    logic        i_wr_stb;
    logic [7:0]  i_wr_data;
    logic        o_wr_ready;

    // upstream read byte stream
    logic        o_rd_valid;
    logic [7:0]  o_rd_data;
    logic        i_rd_ready;

    // status
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    // CIA register target side
    logic        o_activate;
    logic        o_write_flag;
    logic        o_inc_addr;
    logic [17:0] o_address;
    logic [17:0] o_data_count;
    logic        o_target_ready;
    logic        i_target_ready;
    logic        i_target_finished;
    logic        o_data_stb;
    logic [7:0]  o_data;
    logic        i_data_stb;
    logic [7:0]  i_data;

    modport slave (
        input  i_cmd_stb, i_write_flag, i_inc_addr, i_address, i_data_count, i_abort,
        input  i_wr_stb, i_wr_data,
        output o_wr_ready,
        output o_rd_valid, o_rd_data,
        input  i_rd_ready,
        output o_busy, o_done, o_error,
        output o_activate, o_write_flag, o_inc_addr, o_address, o_data_count,
        output o_target_ready,
        input  i_target_ready, i_target_finished,
        output o_data_stb, o_data,
        input  i_data_stb, i_data
    );

    modport master (
        output i_cmd_stb, i_write_flag, i_inc_addr, i_address, i_data_count, i_abort,
        output i_wr_stb, i_wr_data,
        input  o_wr_ready,
        input  o_rd_valid, o_rd_data,
        output i_rd_ready,
        input  o_busy, o_done, o_error,
        input  o_activate, o_write_flag, o_inc_addr, o_address, o_data_count,
        input  o_target_ready,
        output i_target_ready, i_target_finished,
        input  o_data_stb, o_data,
        output i_data_stb, i_data
    );

endinterface

// File: rtl/sdio_cia_xfer_ctrl.sv
// Byte-transfer sequencer between the SDIO command/data layer and one CIA
// register target (CIS, CCCR or FBR). A CMD52/CMD53 request is latched in
// IDLE, then bytes move one at a time through a one-entry write buffer
// (upstream -> target) or a one-entry read buffer (target -> upstream)
// while the remaining count and current address are tracked.
//
// Optional feature: define SDIO_CIA_TIMEOUT_EN to build a progress watchdog
// that aborts the transfer and raises o_error after TIMEOUT_CYCLES cycles
// without a byte moving or the state changing. Without the macro o_error
// is constant 0 and TIMEOUT_CYCLES has no effect.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for i_cmd_stb
// ACTIVATE | first cycle of o_activate, target sees the latched request
// XFER     | bytes moving; ends when the count runs out or target finishes
// WAIT_FIN | all bytes moved, waiting for i_target_finished
// DONE     | one-cycle o_done pulse
module sdio_cia_xfer_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    sdio_cia_xfer_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACTIVATE = 3'd1,
        ST_XFER     = 3'd2,
        ST_WAIT_FIN = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next_nom;
    state_t      state_next;

    logic        write_flag_q;
    logic        inc_addr_q;
    logic [17:0] address_q;
    logic [17:0] data_count_q;
    logic [17:0] remaining;
    logic [17:0] req_count;

    logic        wr_full;
    logic [7:0]  wr_buf;
    logic        rd_valid;
    logic [7:0]  rd_data;

    logic        cmd_accept;
    logic        in_xfer;
    logic        wr_ready_int;
    logic        tgt_ready_int;
    logic        wr_cap;
    logic        wr_push;
    logic        rd_load;
    logic        byte_evt;
    logic        last_byte;
    logic        timeout_hit;
    logic        abort_evt;

    // A zero byte count is the SDIO encoding for a full 512-byte block.
    assign req_count     = (bus.i_data_count == 18'd0) ? 18'd512 : bus.i_data_count;

    assign cmd_accept    = (state == ST_IDLE) && bus.i_cmd_stb;
    assign in_xfer       = (state == ST_XFER);

    // Handshake terms. A user abort blocks every byte movement in its cycle.
    assign wr_ready_int  = in_xfer && write_flag_q && !wr_full;
    assign tgt_ready_int = in_xfer && !write_flag_q && (!rd_valid || bus.i_rd_ready);
    assign wr_cap        = wr_ready_int && bus.i_wr_stb && !bus.i_abort;
    assign wr_push       = in_xfer && write_flag_q && wr_full && bus.i_target_ready && !bus.i_abort;
    assign rd_load       = tgt_ready_int && bus.i_data_stb && !bus.i_abort;
    assign byte_evt      = wr_push || rd_load;
    assign last_byte     = byte_evt && (remaining == 18'd1);

    assign abort_evt     = (state != ST_IDLE) && (bus.i_abort || timeout_hit);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state ignoring the watchdog; the watchdog decides on this value,
    // so the timeout override is applied separately below.
    always_comb begin
        state_next_nom = state;
        case (state)
            ST_IDLE: begin
                if (bus.i_cmd_stb) begin
                    state_next_nom = ST_ACTIVATE;
                end
            end
            ST_ACTIVATE: begin
                state_next_nom = ST_XFER;
            end
            ST_XFER: begin
                if (bus.i_target_finished) begin
                    state_next_nom = ST_DONE;
                end else if (last_byte) begin
                    state_next_nom = ST_WAIT_FIN;
                end
            end
            ST_WAIT_FIN: begin
                if (bus.i_target_finished) begin
                    state_next_nom = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next_nom = ST_IDLE;
            end
            default: begin
                state_next_nom = ST_IDLE;
            end
        endcase
        if ((state != ST_IDLE) && bus.i_abort) begin
            state_next_nom = ST_IDLE;
        end
    end

    assign state_next = timeout_hit ? ST_IDLE : state_next_nom;

    // State-decoded outputs and target/upstream handshakes.
    always_comb begin
        bus.o_busy         = (state != ST_IDLE);
        bus.o_activate     = 1'b0;
        bus.o_done         = 1'b0;
        bus.o_wr_ready     = wr_ready_int;
        bus.o_target_ready = tgt_ready_int;
        bus.o_data_stb     = wr_push;
        case (state)
            ST_ACTIVATE, ST_XFER, ST_WAIT_FIN: bus.o_activate = 1'b1;
            // the watchdog never runs in DONE, so only a user abort suppresses the pulse
            ST_DONE:                           bus.o_done     = !bus.i_abort;
            default:                           bus.o_activate = 1'b0;
        endcase
    end

    // Request latch plus per-byte count and address tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_flag_q <= 1'b0;
            inc_addr_q   <= 1'b0;
            address_q    <= 18'd0;
            data_count_q <= 18'd0;
            remaining    <= 18'd0;
        end else if (cmd_accept) begin
            write_flag_q <= bus.i_write_flag;
            inc_addr_q   <= bus.i_inc_addr;
            address_q    <= bus.i_address;
            data_count_q <= req_count;
            remaining    <= req_count;
        end else if (byte_evt) begin
            remaining <= remaining - 18'd1;
            if (inc_addr_q) begin
                address_q <= address_q + 18'd1;
            end
        end
    end

    // One-entry write buffer: filled from upstream, drained by o_data_stb.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_full <= 1'b0;
            wr_buf  <= 8'h00;
        end else if (abort_evt) begin
            wr_full <= 1'b0;
        end else if (wr_cap) begin
            wr_full <= 1'b1;
            wr_buf  <= bus.i_wr_data;
        end else if (wr_push) begin
            wr_full <= 1'b0;
        end
    end

    // One-entry read buffer: a load in the same cycle as an accept keeps it valid,
    // and a pending byte survives into DONE/IDLE until upstream takes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
        end else if (abort_evt) begin
            rd_valid <= 1'b0;
        end else if (rd_load) begin
            rd_valid <= 1'b1;
            rd_data  <= bus.i_data;
        end else if (bus.i_rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

    assign bus.o_write_flag = write_flag_q;
    assign bus.o_inc_addr   = inc_addr_q;
    assign bus.o_address    = address_q;
    assign bus.o_data_count = data_count_q;
    assign bus.o_data       = wr_buf;
    assign bus.o_rd_valid   = rd_valid;
    assign bus.o_rd_data    = rd_data;

`ifdef SDIO_CIA_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_active;
    logic            progress;
    logic            error_q;

    assign wd_active   = (state == ST_ACTIVATE) || (state == ST_XFER) || (state == ST_WAIT_FIN);
    assign progress    = byte_evt || (state_next_nom != state);
    // Terminal count reached on a cycle that again shows no progress.
    assign timeout_hit = wd_active && !progress && (wd_cnt == '0);

    // Progress watchdog: down-counter reloaded on any byte or state change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt <= WD_LOAD;
        end else if (!wd_active || progress) begin
            wd_cnt <= WD_LOAD;
        end else if (wd_cnt != '0) begin
            wd_cnt <= wd_cnt - 1'b1;
        end
    end

    // Sticky timeout flag, cleared when the next request is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            error_q <= 1'b0;
        end else if (cmd_accept) begin
            error_q <= 1'b0;
        end else if (timeout_hit) begin
            error_q <= 1'b1;
        end
    end

    assign bus.o_error = error_q;
`else
    // TIMEOUT_CYCLES only matters when the watchdog is built.
    logic unused_cfg;
    assign unused_cfg  = ^TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign bus.o_error = 1'b0;
`endif

endmodule

// File: tb/tb_sdio_cia_xfer_ctrl.sv
// Directed bench for sdio_cia_xfer_ctrl. Inputs change just after the falling
// edge; outputs are checked 1 time unit later, well away from the rising edge.
module tb_sdio_cia_xfer_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sdio_cia_xfer_ctrl_if bus();

    sdio_cia_xfer_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue_cmd(input logic wr, input logic inc, input logic [17:0] addr,
                             input logic [17:0] cnt);
        bus.i_write_flag = wr;
        bus.i_inc_addr   = inc;
        bus.i_address    = addr;
        bus.i_data_count = cnt;
        bus.i_cmd_stb    = 1'b1;
        step();
        bus.i_cmd_stb    = 1'b0;
    endtask

    // Push one byte through the write buffer with the target ready.
    task automatic write_byte(input logic [7:0] data, input logic [17:0] exp_addr);
        bus.i_wr_stb  = 1'b1;
        bus.i_wr_data = data;
        #1 check("wr_ready_empty", bus.o_wr_ready, 1);
        step();
        bus.i_wr_stb  = 1'b0;
        #1;
        check("data_stb", bus.o_data_stb, 1);
        check("data_out", bus.o_data, data);
        check("addr_at_stb", bus.o_address, exp_addr);
        step();
    endtask

    // Finish from WAIT_FIN/XFER and walk back to IDLE.
    task automatic finish_xfer();
        bus.i_target_finished = 1'b1;
        step();
        bus.i_target_finished = 1'b0;
        #1;
        check("done_pulse", bus.o_done, 1);
        check("act_dropped", bus.o_activate, 0);
        step();
        #1;
        check("done_single", bus.o_done, 0);
        check("idle_busy", bus.o_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int  n;
        logic seen;
        logic reached;

        rst                   = 1'b0;
        bus.i_cmd_stb         = 1'b0;
        bus.i_write_flag      = 1'b0;
        bus.i_inc_addr        = 1'b0;
        bus.i_address         = 18'd0;
        bus.i_data_count      = 18'd0;
        bus.i_abort           = 1'b0;
        bus.i_wr_stb          = 1'b0;
        bus.i_wr_data         = 8'h00;
        bus.i_rd_ready        = 1'b0;
        bus.i_target_ready    = 1'b0;
        bus.i_target_finished = 1'b0;
        bus.i_data_stb        = 1'b0;
        bus.i_data            = 8'h00;

        @(negedge clk);
        step();
        step();
        #1;
        check("rst_busy", bus.o_busy, 0);
        check("rst_act", bus.o_activate, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_error", bus.o_error, 0);
        check("rst_addr", bus.o_address, 0);
        check("rst_count", bus.o_data_count, 0);
        check("rst_rd_valid", bus.o_rd_valid, 0);
        check("rst_wr_ready", bus.o_wr_ready, 0);
        check("rst_tgt_ready", bus.o_target_ready, 0);
        check("rst_data_stb", bus.o_data_stb, 0);
        check("rst_wflag", bus.o_write_flag, 0);
        rst = 1'b1;
        step();

        // ---- write, count 4, inc, 0x01000, bytes A0..A3, target stall on byte 1
        issue_cmd(1'b1, 1'b1, 18'h01000, 18'd4);
        #1;
        check("w_act", bus.o_activate, 1);
        check("w_busy", bus.o_busy, 1);
        check("w_count", bus.o_data_count, 4);
        check("w_wflag", bus.o_write_flag, 1);
        check("w_ready_in_act", bus.o_wr_ready, 0);
        step();
        bus.i_target_ready = 1'b1;
        write_byte(8'hA0, 18'h01000);
        bus.i_target_ready = 1'b0;
        bus.i_wr_stb  = 1'b1;
        bus.i_wr_data = 8'hA1;
        step();
        bus.i_wr_data = 8'hEE;
        #1;
        check("w_full_not_ready", bus.o_wr_ready, 0);
        check("w_stall_no_stb", bus.o_data_stb, 0);
        step();
        bus.i_wr_stb       = 1'b0;
        bus.i_target_ready = 1'b1;
        #1;
        check("w_stb_after_stall", bus.o_data_stb, 1);
        check("w_kept_byte", bus.o_data, 8'hA1);
        check("w_addr1", bus.o_address, 18'h01001);
        step();
        write_byte(8'hA2, 18'h01002);
        write_byte(8'hA3, 18'h01003);
        #1;
        check("wf_wr_ready", bus.o_wr_ready, 0);
        check("wf_act", bus.o_activate, 1);
        check("wf_addr", bus.o_address, 18'h01004);
        check("wf_no_done", bus.o_done, 0);
        step();
        #1 check("wf_holds", bus.o_busy, 1);
        finish_xfer();

        // ---- read, count 3, no inc, 0x00009, upstream stalled 5 cycles
        bus.i_rd_ready = 1'b0;
        issue_cmd(1'b0, 1'b0, 18'h00009, 18'd3);
        #1;
        check("r_count", bus.o_data_count, 3);
        check("r_tgt_in_act", bus.o_target_ready, 0);
        step();
        bus.i_data_stb = 1'b1;
        bus.i_data     = 8'h51;
        #1 check("r_tgt_ready", bus.o_target_ready, 1);
        step();
        bus.i_data_stb = 1'b0;
        #1;
        check("r_valid0", bus.o_rd_valid, 1);
        check("r_data0", bus.o_rd_data, 8'h51);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.i_data_stb = 1'b1;
                bus.i_data     = 8'h99;
                bus.i_cmd_stb  = 1'b1;
                bus.i_address  = 18'h00003;
            end
            #1 check("r_stall_tgt", bus.o_target_ready, 0);
            step();
            bus.i_data_stb = 1'b0;
            bus.i_cmd_stb  = 1'b0;
        end
        #1;
        check("r_stall_data", bus.o_rd_data, 8'h51);
        check("r_stall_addr", bus.o_address, 18'h00009);
        bus.i_rd_ready = 1'b1;
        bus.i_data_stb = 1'b1;
        bus.i_data     = 8'h52;
        #1 check("r_tgt_pass", bus.o_target_ready, 1);
        step();
        bus.i_rd_ready = 1'b0;
        bus.i_data_stb = 1'b0;
        #1;
        check("r_valid1", bus.o_rd_valid, 1);
        check("r_data1", bus.o_rd_data, 8'h52);
        bus.i_rd_ready = 1'b1;
        step();
        bus.i_rd_ready = 1'b0;
        #1 check("r_accept_clears", bus.o_rd_valid, 0);
        bus.i_data_stb = 1'b1;
        bus.i_data     = 8'h53;
        step();
        bus.i_data_stb = 1'b0;
        #1;
        check("r_valid2", bus.o_rd_valid, 1);
        check("r_data2", bus.o_rd_data, 8'h53);
        check("r_waitfin_tgt", bus.o_target_ready, 0);
        check("r_addr_fixed", bus.o_address, 18'h00009);
        check("r_count_kept", bus.o_data_count, 3);
        check("r_act", bus.o_activate, 1);
        finish_xfer();
        check("r_pending_idle", bus.o_rd_valid, 1);
        bus.i_rd_ready = 1'b1;
        step();
        bus.i_rd_ready = 1'b0;
        #1 check("r_pending_taken", bus.o_rd_valid, 0);

        // ---- count 0 -> 512 byte read, inc from 0x00100
        issue_cmd(1'b0, 1'b1, 18'h00100, 18'd0);
        #1 check("c0_count", bus.o_data_count, 512);
        step();
        bus.i_rd_ready = 1'b1;
        n       = 0;
        reached = 1'b0;
        for (int k = 0; k < 600; k++) begin
            bus.i_data_stb = 1'b1;
            bus.i_data     = n[7:0];
            #1;
            if (!bus.o_target_ready) begin
                reached = 1'b1;
                break;
            end
            n++;
            step();
        end
        bus.i_data_stb = 1'b0;
        check("c0_reached_waitfin", reached, 1);
        check("c0_bytes", n, 512);
        check("c0_addr", bus.o_address, 18'h00300);
        check("c0_last", bus.o_rd_data, 8'hFF);
        finish_xfer();
        bus.i_rd_ready = 1'b0;

        // ---- address wrap 3FFFF -> 00000
        issue_cmd(1'b1, 1'b1, 18'h3FFFF, 18'd2);
        step();
        write_byte(8'h11, 18'h3FFFF);
        write_byte(8'h22, 18'h00000);
        #1 check("wrap_addr_end", bus.o_address, 18'h00001);
        finish_xfer();

        // ---- abort after 2 of 8 bytes, abort wins over a same-cycle write
        issue_cmd(1'b1, 1'b1, 18'h00020, 18'd8);
        step();
        write_byte(8'h31, 18'h00020);
        write_byte(8'h32, 18'h00021);
        bus.i_wr_stb  = 1'b1;
        bus.i_wr_data = 8'h33;
        bus.i_abort   = 1'b1;
        step();
        bus.i_wr_stb  = 1'b0;
        bus.i_abort   = 1'b0;
        #1;
        check("ab_busy", bus.o_busy, 0);
        check("ab_act", bus.o_activate, 0);
        check("ab_addr", bus.o_address, 18'h00022);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.o_done) seen = 1'b1;
            step();
            #1;
        end
        check("ab_no_done", seen, 0);
        issue_cmd(1'b1, 1'b1, 18'h00040, 18'd1);
        step();
        #1;
        check("ab_buf_cleared", bus.o_data_stb, 0);
        write_byte(8'h44, 18'h00040);
        bus.i_abort = 1'b1;
        #1 check("ab_wf_no_done", bus.o_done, 0);
        step();
        bus.i_abort = 1'b0;
        #1 check("ab_wf_idle", bus.o_busy, 0);

        // ---- target finishes early during XFER
        issue_cmd(1'b0, 1'b0, 18'h00005, 18'd8);
        step();
        bus.i_rd_ready = 1'b1;
        bus.i_data_stb = 1'b1;
        bus.i_data     = 8'h61;
        step();
        bus.i_data_stb = 1'b0;
        #1 check("early_data", bus.o_rd_data, 8'h61);
        finish_xfer();
        bus.i_rd_ready = 1'b0;

`ifdef SDIO_CIA_TIMEOUT_EN
        // ---- silent target: watchdog fires after 16 cycles in XFER
        bus.i_target_ready = 1'b0;
        issue_cmd(1'b1, 1'b0, 18'h00000, 18'd4);
        #1 check("to_err_clear", bus.o_error, 0);
        step();
        n = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!bus.o_busy) break;
            step();
            n++;
        end
        check("to_cycles", n, 16);
        check("to_error", bus.o_error, 1);
        check("to_act", bus.o_activate, 0);
        issue_cmd(1'b0, 1'b0, 18'h00000, 18'd1);
        #1 check("to_err_cleared", bus.o_error, 0);
        bus.i_abort = 1'b1;
        step();
        bus.i_abort = 1'b0;
`else
        #1 check("no_wd_error", bus.o_error, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
